// File: rtl/aes256_encryption_core_if.sv
`default_nettype none
// ============================================================================
// aes256_encryption_core_if : key/block handshake bundle for the AES-256 cipher
// (busy member present when AES_ENC_BUSY_OUT_EN is defined).      Rev 1.0
// ============================================================================
interface aes256_encryption_core_if;
  logic         key_start;
  logic [255:0] Key;
  logic         start;
  logic [127:0] Plaintext;
  logic [127:0] Ciphertext;
  logic         finished;
  logic         key_finished;
`ifdef AES_ENC_BUSY_OUT_EN
  logic         busy;
`endif

  modport master (
    output key_start, Key, start, Plaintext,
`ifdef AES_ENC_BUSY_OUT_EN
    input  busy,
`endif
    input  Ciphertext, finished, key_finished
  );

  modport slave (
    input  key_start, Key, start, Plaintext,
`ifdef AES_ENC_BUSY_OUT_EN
    output busy,
`endif
    output Ciphertext, finished, key_finished
  );
endinterface
`default_nettype wire

// File: rtl/aes256_encryption_core.sv
`default_nettype none
// ============================================================================
// aes256_encryption_core : iterative AES-256 encryption, one round per clock.
// Optional busy output enabled by macro AES_ENC_BUSY_OUT_EN.       Rev 1.0
// ============================================================================

module aes_sbox (
  input  wire logic [7:0] din,
  output logic      [7:0] dout
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  logic [7:0] w_inv;
  logic [7:0] w_sq;

  // Inverse computed as din^254 (bits 1..7 of the exponent), which maps 0 to 0.
  always_comb begin
    w_inv = 8'h01;
    w_sq  = din;
    for (int i = 1; i < 8; i++) begin
      w_sq  = gmul(w_sq, w_sq);
      w_inv = gmul(w_inv, w_sq);
    end
  end

  assign dout = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes256_encryption_core (
  input wire logic                      CLK,
  input wire logic                      RST_n,
  aes256_encryption_core_if.slave       bus
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_ENC    = 2'd2
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [127:0] r_blk, w_blk_nxt;
  logic [127:0] r_ct, w_ct_nxt;
  logic         r_fin, w_fin_nxt;
  logic         r_kf, w_kf_nxt;
  logic [127:0] r_rk [0:14];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Cipher round datapath
  logic [127:0] w_sub, w_shift, w_rk_cur, w_mid, w_final;

  for (genvar g = 0; g < 16; g++) begin : g_state_sbox
    aes_sbox u_sbox (.din(r_blk[127-8*g -: 8]), .dout(w_sub[127-8*g -: 8]));
  end

  assign w_shift  = shift_rows(w_sub);
  assign w_rk_cur = r_rk[r_round];
  assign w_mid    = mix_columns(w_shift) ^ w_rk_cur;
  assign w_final  = w_shift ^ w_rk_cur;

  // Key schedule: r_round doubles as the index i of the round key being built.
  logic [127:0] w_prev1, w_prev2;
  logic [31:0]  w_kw_in, w_kw_sub, w_temp;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [7:0]   w_rcon;

  assign w_prev1 = r_rk[r_round - 4'd1];
  assign w_prev2 = r_rk[r_round - 4'd2];
  assign w_kw_in = r_round[0] ? w_prev1[31:0] : {w_prev1[23:0], w_prev1[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (.din(w_kw_in[31-8*g -: 8]), .dout(w_kw_sub[31-8*g -: 8]));
  end

  assign w_rcon = 8'h01 << (r_round[3:1] - 3'd1);
  assign w_temp = r_round[0] ? w_kw_sub : (w_kw_sub ^ {w_rcon, 24'h000000});
  assign w_n0   = w_prev2[127:96] ^ w_temp;
  assign w_n1   = w_prev2[95:64]  ^ w_n0;
  assign w_n2   = w_prev2[63:32]  ^ w_n1;
  assign w_n3   = w_prev2[31:0]   ^ w_n2;

  logic w_key_load;
  assign w_key_load = (r_state == ST_IDLE) && bus.key_start;

  always_ff @(posedge CLK) begin
    if (w_key_load) begin
      r_rk[0] <= bus.Key[255:128];
      r_rk[1] <= bus.Key[127:0];
    end else if (r_state == ST_KEYEXP) begin
      r_rk[r_round] <= {w_n0, w_n1, w_n2, w_n3};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_blk_nxt   = r_blk;
    w_ct_nxt    = r_ct;
    w_fin_nxt   = 1'b0;
    w_kf_nxt    = r_kf;
    case (r_state)
      ST_IDLE: begin
        if (bus.key_start) begin
          w_kf_nxt    = 1'b0;
          w_round_nxt = 4'd2;
          w_state_nxt = ST_KEYEXP;
        end else if (bus.start && r_kf) begin
          w_blk_nxt   = bus.Plaintext ^ r_rk[0];
          w_round_nxt = 4'd1;
          w_state_nxt = ST_ENC;
        end
      end
      ST_KEYEXP: begin
        if (r_round == 4'd14) begin
          w_kf_nxt    = 1'b1;
          w_round_nxt = 4'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_round_nxt = r_round + 4'd1;
        end
      end
      ST_ENC: begin
        if (r_round == 4'd14) begin
          w_ct_nxt    = w_final;
          w_fin_nxt   = 1'b1;
          w_round_nxt = 4'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_blk_nxt   = w_mid;
          w_round_nxt = r_round + 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= ST_IDLE;
      r_round <= 4'd0;
      r_blk   <= '0;
      r_ct    <= '0;
      r_fin   <= 1'b0;
      r_kf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_blk   <= w_blk_nxt;
      r_ct    <= w_ct_nxt;
      r_fin   <= w_fin_nxt;
      r_kf    <= w_kf_nxt;
    end
  end

  assign bus.Ciphertext   = r_ct;
  assign bus.finished     = r_fin;
  assign bus.key_finished = r_kf;
`ifdef AES_ENC_BUSY_OUT_EN
  assign bus.busy         = (r_state != ST_IDLE);
`endif
endmodule
`default_nettype wire

// File: tb/tb_aes256_encryption_core.sv
`default_nettype none
// ============================================================================
// tb_aes256_encryption_core : randomized bench against an AES-256 reference
// model plus FIPS-197 vectors, guard, back-to-back and reset-abort cases. Rev 1.0
// ============================================================================
module tb_aes256_encryption_core;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] ZR_CT  = 128'hdc95c078a2408989ad48a21492842087;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes256_encryption_core_if bus();
  aes256_encryption_core dut (.CLK(clk), .RST_n(rst_n), .bus(bus.slave));

  int total = 0;
  int bad = 0;
  int fin_cnt = 0;
  logic [7:0] sbox [256];

  always @(posedge clk) begin
    #2;
    if (bus.finished) fin_cnt++;
  end

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  // S-box table from the generator walk over GF(2^8) (p by 3, q by 1/3).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [255:0] key, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 14) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
      end
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // Pulse key_start (optionally with start) and wait for the schedule; a start
  // pulse can be injected at cycle inj_at of the expansion.
  task automatic load_key(input logic [255:0] k, input string tag, input bit with_start, input int inj_at);
    int lat;
    int busy_n;
    @(negedge clk);
    bus.Key = k;
    bus.key_start = 1'b1;
    if (with_start) begin
      bus.start = 1'b1;
      bus.Plaintext = rand128();
    end
    @(negedge clk);
    bus.key_start = 1'b0;
    bus.start = 1'b0;
    bus.Key = rand256();
    check_value({tag, "_kfclr"}, bus.key_finished, 0);
    lat = 0;
    busy_n = 0;
    while (!bus.key_finished && lat < 40) begin
`ifdef AES_ENC_BUSY_OUT_EN
      if (bus.busy) busy_n++;
`endif
      if (lat == inj_at) begin
        bus.start = 1'b1;
        bus.Plaintext = rand128();
      end
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
    end
    check_value({tag, "_keylat"}, lat, 13);
`ifdef AES_ENC_BUSY_OUT_EN
    check_value({tag, "_kbusy"}, busy_n, 13);
    check_value({tag, "_kbusy_end"}, bus.busy, 0);
`endif
  endtask

  task automatic start_enc(input logic [127:0] pt);
    @(negedge clk);
    bus.Plaintext = pt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.Plaintext = rand128();
  endtask

  // Called on the negedge after the start edge; returns on the finished cycle.
  task automatic wait_fin(input logic [127:0] exp, input string tag, input int inj_at, input bit inj_key);
    int lat;
    int busy_n;
    lat = 0;
    busy_n = 0;
    while (!bus.finished && lat < 40) begin
`ifdef AES_ENC_BUSY_OUT_EN
      if (bus.busy) busy_n++;
`endif
      if (lat == inj_at) begin
        if (inj_key) bus.key_start = 1'b1;
        else bus.start = 1'b1;
        bus.Plaintext = rand128();
        bus.Key = rand256();
      end
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      bus.key_start = 1'b0;
    end
    check_value({tag, "_enclat"}, lat, 14);
    check_value({tag, "_ct"}, bus.Ciphertext, exp);
`ifdef AES_ENC_BUSY_OUT_EN
    check_value({tag, "_ebusy"}, busy_n, 14);
    check_value({tag, "_ebusy_end"}, bus.busy, 0);
`endif
  endtask

  task automatic encrypt(input logic [127:0] pt, input logic [127:0] exp, input string tag,
                         input int inj_at, input bit inj_key);
    start_enc(pt);
    wait_fin(exp, tag, inj_at, inj_key);
    @(negedge clk);
    check_value({tag, "_width"}, bus.finished, 0);
  endtask

  initial begin
    int f0;
    logic [255:0] k;
    logic [127:0] pt, pt2;
    bus.key_start = 1'b0;
    bus.start = 1'b0;
    bus.Key = '0;
    bus.Plaintext = '0;
    rst_n = 1'b0;
    build_sbox();
    repeat (3) @(negedge clk);
    check_value("rst_ct", bus.Ciphertext, 0);
    check_value("rst_fin", bus.finished, 0);
    check_value("rst_kf", bus.key_finished, 0);
`ifdef AES_ENC_BUSY_OUT_EN
    check_value("rst_busy", bus.busy, 0);
`endif
    rst_n = 1'b1;

    f0 = fin_cnt;
    start_enc(rand128());
    repeat (20) @(negedge clk);
    check_value("nokey_fin", fin_cnt - f0, 0);
    check_value("nokey_ct", bus.Ciphertext, 0);

    check_value("ref_c3", ref_encrypt(C3_KEY, C3_PT), C3_CT);
    load_key(C3_KEY, "c3", 1'b0, -1);
    encrypt(C3_PT, C3_CT, "c3", -1, 1'b0);

    f0 = fin_cnt;
    load_key('0, "zero", 1'b0, 5);
    repeat (3) @(negedge clk);
    check_value("kexp_start_fin", fin_cnt - f0, 0);
    check_value("kexp_start_ct", bus.Ciphertext, C3_CT);
    encrypt('0, ZR_CT, "zero", -1, 1'b0);

    f0 = fin_cnt;
    encrypt('0, ZR_CT, "enc_start", 5, 1'b0);
    repeat (20) @(negedge clk);
    check_value("enc_start_pulses", fin_cnt - f0, 1);

    pt = rand128();
    encrypt(pt, ref_encrypt('0, pt), "enc_key", 4, 1'b1);
    check_value("enc_key_kf", bus.key_finished, 1);
    pt = rand128();
    encrypt(pt, ref_encrypt('0, pt), "enc_key2", -1, 1'b0);

    f0 = fin_cnt;
    k = rand256();
    load_key(k, "simul", 1'b1, -1);
    repeat (3) @(negedge clk);
    check_value("simul_fin", fin_cnt - f0, 0);
    pt = rand128();
    encrypt(pt, ref_encrypt(k, pt), "simul", -1, 1'b0);

    k = rand256();
    load_key(k, "b2b", 1'b0, -1);
    pt = rand128();
    pt2 = rand128();
    start_enc(pt);
    wait_fin(ref_encrypt(k, pt), "b2b1", -1, 1'b0);
    bus.Plaintext = pt2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.Plaintext = rand128();
    check_value("b2b1_width", bus.finished, 0);
    wait_fin(ref_encrypt(k, pt2), "b2b2", -1, 1'b0);
    @(negedge clk);
    check_value("b2b2_width", bus.finished, 0);

    for (int n = 0; n < 3; n++) begin
      k = rand256();
      load_key(k, $sformatf("rnd%0d", n), 1'b0, -1);
      for (int b = 0; b < 2; b++) begin
        pt = rand128();
        encrypt(pt, ref_encrypt(k, pt), $sformatf("rnd%0d_%0d", n, b), -1, 1'b0);
      end
    end

    load_key(C3_KEY, "abort", 1'b0, -1);
    start_enc(C3_PT);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_value("abort_ct", bus.Ciphertext, 0);
    check_value("abort_fin", bus.finished, 0);
    check_value("abort_kf", bus.key_finished, 0);
`ifdef AES_ENC_BUSY_OUT_EN
    check_value("abort_busy", bus.busy, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = fin_cnt;
    start_enc(C3_PT);
    repeat (20) @(negedge clk);
    check_value("abort_start_fin", fin_cnt - f0, 0);
    check_value("abort_start_ct", bus.Ciphertext, 0);
    load_key(C3_KEY, "abort_rk", 1'b0, -1);
    encrypt(C3_PT, C3_CT, "abort_c3", -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
